// File: rtl/dram_pattest.sv
// Self-running DRAM pattern tester: writes an LFSR pattern over 0..LAST_ADDR,
// reads it back, compares, and reports progress on a blink output.
module dram_pattest #(
  parameter logic [20:0] LAST_ADDR  = 21'h1FFFFF,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [23:0] BLINK_SLOW = 24'd13999999,
  parameter logic [23:0] BLINK_FAST = 24'd3499999
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cbeg,
  input  logic        rrdy,
  input  logic [15:0] rddata,
  output logic        req,
  output logic        rnw,
  output logic [20:0] addr,
  output logic [15:0] wrdata,
  output logic [1:0]  bsel,
  output logic        busy,
  output logic [7:0]  pass_cnt,
  output logic        err,
  output logic [20:0] err_addr,
  output logic [15:0] err_data,
  output logic        led,
  output logic [2:0]  state
);

  // Handshake: a request (req/rnw/addr/wrdata) is accepted on any edge where
  // cbeg=1 and req=1; all request outputs are held until the edge after that.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    FAIL = 3'd4
  } state_t;

  state_t      st;
  logic [15:0] lfsr;
  logic [23:0] cnt;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] pass_seed(input logic [7:0] pc);
    logic [15:0] s;
    s = SEED ^ {8'h00, pc};
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] pattern(input logic [15:0] l, input logic inv);
    return inv ? ~l : l;
  endfunction

  logic        accept;
  logic        last;
  logic        rd_match;
  logic [15:0] l_next;
  logic [15:0] seed_now;
  logic [15:0] seed_succ;
  logic [7:0]  pc_succ;

  assign accept    = cbeg & req;
  assign last      = (addr == LAST_ADDR);
  assign l_next    = lfsr_next(lfsr);
  assign pc_succ   = pass_cnt + 8'd1;
  assign seed_now  = pass_seed(pass_cnt);
  assign seed_succ = pass_seed(pc_succ);
  assign rd_match  = (rddata == pattern(lfsr, pass_cnt[0]));

  assign bsel  = 2'b11;
  assign busy  = (st != IDLE) && (st != FAIL);
  assign state = st;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      req      <= 1'b0;
      rnw      <= 1'b1;
      addr     <= '0;
      wrdata   <= '0;
      lfsr     <= SEED;
      pass_cnt <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (en) begin
            lfsr   <= seed_now;
            wrdata <= pattern(seed_now, pass_cnt[0]);
            addr   <= '0;
            rnw    <= 1'b0;
            req    <= 1'b1;
            st     <= WR;
          end
        end
        WR: begin
          if (accept) begin
            if (!last) begin
              addr   <= addr + 21'd1;
              lfsr   <= l_next;
              wrdata <= pattern(l_next, pass_cnt[0]);
            end else begin
              addr <= '0;
              lfsr <= seed_now;
              rnw  <= 1'b1;
              st   <= RD;
            end
          end
        end
        RD: begin
          if (accept) begin
            req <= 1'b0;
            st  <= RDW;
          end
        end
        RDW: begin
          if (rrdy) begin
            if (!rd_match) begin
              err      <= 1'b1;
              err_addr <= addr;
              err_data <= rddata;
              st       <= FAIL;
            end else if (!last) begin
              addr <= addr + 21'd1;
              lfsr <= l_next;
              req  <= 1'b1;
              st   <= RD;
            end else begin
              // End of pass: en is only looked at here and in IDLE.
              pass_cnt <= pc_succ;
              addr     <= '0;
              if (en) begin
                lfsr   <= seed_succ;
                wrdata <= pattern(seed_succ, pc_succ[0]);
                rnw    <= 1'b0;
                req    <= 1'b1;
                st     <= WR;
              end else begin
                st <= IDLE;
              end
            end
          end
        end
        FAIL: begin
          req <= 1'b0;
        end
        default: begin
          req <= 1'b0;
          st  <= IDLE;
        end
      endcase
    end
  end

  // Blink: solid off while idle and clean, slow while running, fast after error.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b1;
      cnt <= BLINK_SLOW;
    end else if (st == IDLE && !err) begin
      led <= 1'b1;
      cnt <= BLINK_SLOW;
    end else if (cnt == 24'd0) begin
      cnt <= err ? BLINK_FAST : BLINK_SLOW;
      led <= ~led;
    end else begin
      cnt <= cnt - 24'd1;
    end
  end

endmodule

// File: tb/tb_dram_pattest.sv
// Bench for dram_pattest: small DRAM model, transaction-level reference model
// of the write/read stream, and directed scenarios with literal expectations.
module tb_dram_pattest;

  localparam logic [20:0] LAST_ADDR  = 21'd7;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam logic [23:0] BLINK_SLOW = 24'd9;
  localparam logic [23:0] BLINK_FAST = 24'd3;
  localparam int          W          = 38;

  logic        fclk   = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        cbeg   = 1'b0;
  logic        rrdy   = 1'b0;
  logic [15:0] rddata = 16'h0000;
  logic        req;
  logic        rnw;
  logic [20:0] addr;
  logic [15:0] wrdata;
  logic [1:0]  bsel;
  logic        busy;
  logic [7:0]  pass_cnt;
  logic        err;
  logic [20:0] err_addr;
  logic [15:0] err_data;
  logic        led;
  logic [2:0]  state;

  // ---------------- clock / reset block ----------------
  initial forever #5 fclk = ~fclk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dram_pattest #(
    .LAST_ADDR (LAST_ADDR),
    .SEED      (SEED),
    .BLINK_SLOW(BLINK_SLOW),
    .BLINK_FAST(BLINK_FAST)
  ) dut (
    .fclk    (fclk),
    .rst_n   (rst_n),
    .en      (en),
    .cbeg    (cbeg),
    .rrdy    (rrdy),
    .rddata  (rddata),
    .req     (req),
    .rnw     (rnw),
    .addr    (addr),
    .wrdata  (wrdata),
    .bsel    (bsel),
    .busy    (busy),
    .pass_cnt(pass_cnt),
    .err     (err),
    .err_addr(err_addr),
    .err_data(err_data),
    .led     (led),
    .state   (state)
  );

  // ---------------- scoreboard state ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] wlog[$];
  logic [15:0] mem [0:7];
  int          cyc = 0;
  int          rd_cd = -1;
  logic [2:0]  rd_a = 3'd0;
  logic        corrupt_en = 1'b0;
  logic [2:0]  corrupt_addr = 3'd0;
  logic        spur_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- reference model ----------------
  // Word i of pass p: the LFSR stepped i times from the pass seed, inverted on odd passes.
  function automatic logic [15:0] model_word(input int p, input int i);
    logic [15:0] l;
    l = SEED ^ 16'(p & 255);
    if (l == 16'h0000) l = 16'h0001;
    repeat (i) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    return (p % 2 == 1) ? ~l : l;
  endfunction

  task automatic push_pass(input int p, input int nreads);
    for (int i = 0; i <= int'(LAST_ADDR); i++)
      exp_q.push_back({1'b0, 21'(i), model_word(p, i)});
    for (int i = 0; i < nreads; i++)
      exp_q.push_back({1'b1, 21'(i), 16'h0000});
  endtask

  // ---------------- compare process + DRAM model ----------------
  initial begin : compare_and_dram
    logic         acc;
    logic         r;
    logic [20:0]  a;
    logic [15:0]  d;
    logic [W-1:0] e;
    forever begin
      @(negedge fclk);
      acc = 1'b0;
      r   = rnw;
      a   = addr;
      d   = wrdata;
      if (rst_n) begin
        chk("bsel", 32'(bsel), 32'd3);
        acc = cbeg && req;
        if (acc) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: got rnw=%0d addr=%0d, expected no request", r, a);
          end else begin
            e = exp_q.pop_front();
            chk("req_rnw", 32'(r), 32'(e[37]));
            chk("req_addr", 32'(a), 32'(e[36:16]));
            if (!r) chk("wrdata", 32'(d), 32'(e[15:0]));
          end
          if (!r) wlog.push_back(d);
        end
      end
      @(posedge fclk);
      #1;
      cyc++;
      cbeg = (cyc % 4 == 0);
      rrdy = 1'b0;
      if (!rst_n) begin
        rd_cd = -1;
      end else if (rd_cd == 0) begin
        rrdy = 1'b1;
        if (corrupt_en && rd_a == corrupt_addr) begin
          rddata     = 16'h0000;
          corrupt_en = 1'b0;
        end else begin
          rddata = mem[rd_a];
        end
        rd_cd = -1;
      end
      if (spur_req && rst_n) begin
        rrdy     = 1'b1;
        rddata   = 16'h0000;
        spur_req = 1'b0;
      end
      if (acc && r) begin
        rd_cd = 0;
        rd_a  = a[2:0];
      end
      if (acc && !r) mem[a[2:0]] = d;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_rnw"}, 32'(rnw), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_wrdata"}, 32'(wrdata), 32'd0);
    chk({tag, "_bsel"}, 32'(bsel), 32'd3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    chk({tag, "_err_data"}, 32'(err_data), 32'd0);
    chk({tag, "_led"}, 32'(led), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n      = 1'b0;
    en         = 1'b0;
    corrupt_en = 1'b0;
    spur_req   = 1'b0;
    repeat (3) @(negedge fclk);
    exp_q.delete();
    wlog.delete();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    check_reset_vals(tag);
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(input int n, input string name);
    int k;
    for (k = 0; k < 400 && wlog.size() < n; k++) @(negedge fclk);
    if (wlog.size() < n) timeout(name);
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    for (k = 0; k < 3000 && busy; k++) @(negedge fclk);
    if (busy) timeout(name);
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    int k;
    logic prev;

    // 1: reset values, first three writes
    do_reset("rst1");
    push_pass(0, 8);
    en = 1'b1;
    wait_writes(3, "t1_writes");
    chk("t1_wr0", 32'(wlog[0]), 32'h0000ACE1);
    chk("t1_wr1", 32'(wlog[1]), 32'h0000E270);
    chk("t1_wr2", 32'(wlog[2]), 32'h00007138);
    en = 1'b0;
    wait_not_busy("t1_idle");
    chk("t1_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: two clean passes
    do_reset("rst2");
    push_pass(0, 8);
    push_pass(1, 8);
    en = 1'b1;
    for (k = 0; k < 3000 && pass_cnt != 8'd1; k++) @(negedge fclk);
    if (pass_cnt != 8'd1) timeout("t2_pass1");
    en = 1'b0;
    wait_not_busy("t2_idle");
    chk("t2_pass_cnt", 32'(pass_cnt), 32'd2);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_p1_wr0", 32'(wlog[8]), 32'h0000531F);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_led_idle", 32'(led), 32'd1);

    // 3: corrupted read at addr 5
    do_reset("rst3");
    corrupt_addr = 3'd5;
    corrupt_en   = 1'b1;
    push_pass(0, 6);
    en = 1'b1;
    for (k = 0; k < 3000 && !err; k++) @(negedge fclk);
    if (!err) timeout("t3_err");
    en = 1'b0;
    chk("t3_err_addr", 32'(err_addr), 32'd5);
    chk("t3_err_data", 32'(err_data), 32'd0);
    chk("t3_req", 32'(req), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge fclk);
    chk("t3_req_held", 32'(req), 32'd0);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    prev = led;
    for (k = 0; k < 20 && led == prev; k++) @(negedge fclk);
    if (led == prev) timeout("t3_led_sync");
    for (int t = 0; t < 3; t++) begin
      prev = led;
      for (k = 0; k < 20 && led == prev; k++) @(negedge fclk);
      chk("t3_led_interval", 32'(k), 32'd4);
    end
    chk("t3_err_sticky", 32'(err), 32'd1);

    // 4: en dropped mid-WR; pass completes, then idle with led off
    do_reset("rst4");
    push_pass(0, 8);
    en = 1'b1;
    wait_writes(2, "t4_writes");
    en = 1'b0;
    wait_not_busy("t4_idle");
    chk("t4_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
    for (int t = 0; t < 4; t++) begin
      repeat (7) @(negedge fclk);
      chk("t4_led_held", 32'(led), 32'd1);
      chk("t4_stay_idle", 32'(busy), 32'd0);
    end

    // 5: spurious rrdy with wrong data during WR
    do_reset("rst5");
    push_pass(0, 8);
    en = 1'b1;
    wait_writes(1, "t5_writes");
    spur_req = 1'b1;
    repeat (3) @(negedge fclk);
    chk("t5_err_after_spur", 32'(err), 32'd0);
    chk("t5_busy_after_spur", 32'(busy), 32'd1);
    chk("t5_still_writing", 32'(rnw), 32'd0);
    en = 1'b0;
    wait_not_busy("t5_idle");
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset while waiting for read data
    do_reset("rst6");
    push_pass(0, 8);
    en = 1'b1;
    for (k = 0; k < 500 && !(busy && !req); k++) @(negedge fclk);
    if (!(busy && !req)) timeout("t6_rdw");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    do_reset("rst6b");
    push_pass(0, 8);
    en = 1'b1;
    wait_writes(1, "t6_restart");
    chk("t6_restart_wr0", 32'(wlog[0]), 32'h0000ACE1);
    en = 1'b0;
    wait_not_busy("t6_idle");
    chk("t6_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_pattest.md
# dram_pattest

Self-running DRAM pattern tester for the board bring-up test tops. It sits directly upstream of the `dram` controller and drives its `req`/`rnw`/`addr`/`wrdata`/`bsel` request port. It writes a pseudo-random 16-bit pattern over a configurable address range, reads it back and compares each word. Progress and pass/fail status are reported on a blink output suitable for `ide_cs0_n`.

## Interface
- `LAST_ADDR`, 21'h1FFFFF: last word address tested; the range is 0..LAST_ADDR inclusive.
- `SEED`, 16'hACE1: LFSR base seed; must be nonzero.
- `BLINK_SLOW`, 24'd13999999: LED half-period reload value while running with no error.
- `BLINK_FAST`, 24'd3499999: LED half-period reload value after an error.
- `fclk`  in  1: system clock; the only clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `en`  in  1: run enable; level-sensitive.
- `cbeg`  in  1: DRAM cycle-begin strobe. Never asserted on two consecutive cycles.
- `rrdy`  in  1: read-data-valid pulse from the DRAM controller.
- `rddata`  in  16: read data; valid while `rrdy`=1.
- `req`  out  1: access request.
- `rnw`  out  1: 1 = read, 0 = write.
- `addr`  out  21: word address.
- `wrdata`  out  16: write data.
- `bsel`  out  2: byte selects; constant 2'b11.
- `busy`  out  1: high whenever the state is not IDLE or FAIL.
- `pass_cnt`  out  8: number of completed passes; wraps 255→0.
- `err`  out  1: sticky mismatch flag.
- `err_addr`  out  21: address of the first mismatch.
- `err_data`  out  16: `rddata` at the first mismatch.
- `led`  out  1: blink output; 1 = off.

## Operation
- Acceptance: a request is accepted on any cycle with `cbeg`=1 and `req`=1. All request outputs are registered and change only on the cycle after acceptance.
- LFSR: 16-bit Galois. next = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0).
- Pass seed: s = SEED ^ {8'h00, pass_cnt}. If s is 0, 16'h0001 is used instead.
- Expected word: pattern = l when pass_cnt[0]=0, ~l when pass_cnt[0]=1.
- States:
  - IDLE: `req`=0. On `en`=1, load l=s and addr=0, then go to WR.
  - WR: `req`=1, `rnw`=0, `wrdata`=pattern. On acceptance, if addr≠LAST_ADDR, increment addr and advance l. If addr=LAST_ADDR, reload l=s and addr=0, then go to RD.
  - RD: `req`=1, `rnw`=1. On acceptance, drop `req` and go to RDW.
  - RDW: `req`=0; wait for `rrdy`.
    - `rddata`≠pattern: set err=1, latch `err_addr` and `err_data`, go to FAIL.
    - Match with addr≠LAST_ADDR: increment addr, advance l, go to RD.
    - Match with addr=LAST_ADDR: increment pass_cnt. Then go to IDLE if `en`=0, otherwise load the next-pass seed and go to WR.
  - FAIL: `req`=0. Terminal; left only by reset.
- `rrdy` is ignored in every state except RDW.
- `en` is sampled only in IDLE and at the end of a pass. Deasserting `en` mid-pass has no effect until the pass completes.
- LED logic uses a 24-bit down-counter `cnt`.
  - In IDLE with err=0: `led`=1 and `cnt`=BLINK_SLOW.
  - Otherwise, when `cnt`=0: reload `cnt` with err ? BLINK_FAST : BLINK_SLOW and toggle `led`.
  - Otherwise: decrement `cnt`.

## Timing
- Reset values:
  - `req`=0, `rnw`=1, `addr`=0, `wrdata`=0, `bsel`=2'b11.
  - `busy`=0, `pass_cnt`=0, `err`=0, `err_addr`=0, `err_data`=0.
  - `led`=1, `cnt`=BLINK_SLOW, state=IDLE.
- IDLE→WR: `req` rises 1 cycle after `en` is sampled high.
- Writes: back-to-back. The next address and data are presented 1 cycle after acceptance, which is always before the next `cbeg`.
- Reads: one outstanding at a time. The next read request is presented 1 cycle after the `rrdy` that matched.
- WR→RD and pass→pass transitions have a 1-cycle turnaround with no idle request cycle beyond it.
- Error flags: `err`, `err_addr` and `err_data` update 1 cycle after the failing `rrdy`. Only the first mismatch is captured.
- LED period is 2*(reload+1) cycles.
- Asserting `rst_n` mid-access drops `req` immediately (asynchronously) and discards all progress.

## Test plan
Bench setup: LAST_ADDR=7, BLINK_SLOW=9, BLINK_FAST=3. The DRAM model pulses `cbeg` every 4 cycles, returns `rrdy` 2 cycles after each accepted read, and stores data by address.
1. Reset, then `en`=1 → the first three writes present addr 0/1/2 with wrdata 16'hACE1/16'hE270/16'h7138. `bsel` stays 2'b11 throughout.
2. Correct model, `en` held high for 2 passes → pass_cnt reaches 2 and err stays 0. Pass 1 writes ~ACE0 = 16'h531F at addr 0.
3. Model corrupts addr 5 read to 16'h0000 on pass 0 → err=1, err_addr=5, err_data=0, `req` stays 0, `busy`=0, `led` toggles every 4 cycles.
4. `en` dropped during the WR phase of pass 0 → the pass completes, pass_cnt=1, state returns to IDLE, `led`=1 held.
5. Spurious `rrdy` during WR with mismatching data → no error is flagged and no state change occurs.
6. `rst_n` pulsed low while in RDW → all outputs return to their reset values within the same cycle. A fresh `en` restarts at addr 0 with 16'hACE1.
